sample_capture: RTL and testbench

- Writer-side counterpart of the sine lookup ROM: records a stream of DATA_WIDTH samples into an on-chip buffer, starting at a trigger.
- A registered read port returns the stored samples with the same one-cycle latency as the sine ROM.
- Sits between the signal source (ADC/mic sample stream or the generator output) and the Vbuddy/plot readback logic.

---
 rtl/sample_capture_pkg.sv | 18 +
 rtl/capture_ram.sv | 45 ++++
 rtl/sample_capture.sv | 181 ++++++++++++++++++
 tb/tb_sample_capture.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sample_capture_pkg.sv
// sample_capture_pkg: shared types and helpers for the sample capture block.
//   cap_state_t : capture controller state encoding
//   depth_of()  : buffer depth derived from the address width
package sample_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    // Number of buffer entries addressed by an addr_width-bit address.
    function automatic int depth_of(input int addr_width);
        return 32'sd1 <<< addr_width;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer.
//   clk, rst_n          : clock, async active-low reset (read register only)
//   we, waddr, wdata    : synchronous write port
//   raddr, rdata        : registered read port, 1-cycle latency
// The array itself is never reset. A read and a write to the same address
// in one cycle return the previously stored data.
module capture_ram
    import sample_capture_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = depth_of(ADDRESS_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Sample storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read; nonblocking update gives old data on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= '0;
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sample_capture.sv
// sample_capture: records a triggered stream of samples into capture_ram.
//   clk, rst_n : clock, async active-low reset
//   arm        : one-cycle pulse, starts a capture from IDLE or DONE
//   trig       : trigger level, qualified by din_valid
//   din_valid  : din carries a sample this cycle
//   din        : sample input
//   rd_addr    : readback address
//   dout       : readback data, registered, 1-cycle latency
//   busy       : high in ARMED or CAPTURE
//   done       : high in DONE
//   wr_count   : samples written in this capture, saturates at DEPTH
//   trig_addr  : buffer address of the trigger sample
// Build option SAMPLE_CAPTURE_PRETRIG_EN: while ARMED, samples are written
// circularly so the buffer keeps up to PRE_DEPTH samples ahead of the trigger.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int PRE_DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     din_valid,
    input  logic [DATA_WIDTH-1:0]    din,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   wr_count,
    output logic [ADDRESS_WIDTH-1:0] trig_addr
);

    localparam int                   DEPTH     = depth_of(ADDRESS_WIDTH);
    localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT = (ADDRESS_WIDTH+1)'(DEPTH);

    cap_state_t               state_r, state_nxt_s;
    logic [ADDRESS_WIDTH-1:0] wr_addr_r, wr_addr_nxt_s, addr_inc_s;
    logic [ADDRESS_WIDTH:0]   wr_count_r, wr_count_nxt_s, cnt_inc_s, cap_end_s;
    logic [ADDRESS_WIDTH-1:0] trig_addr_r, trig_addr_nxt_s;
    logic                     busy_r, done_r, we_s, trigger_s;

`ifdef SAMPLE_CAPTURE_PRETRIG_EN
    localparam logic [ADDRESS_WIDTH:0] PRE_CNT  = (ADDRESS_WIDTH+1)'(PRE_DEPTH);
    localparam logic [ADDRESS_WIDTH:0] POST_CNT = (ADDRESS_WIDTH+1)'(DEPTH - PRE_DEPTH);
    // Final wr_count of this capture: pre-samples kept plus post-trigger run.
    logic [ADDRESS_WIDTH:0] cap_end_r, cap_end_nxt_s;
    assign cap_end_s = cap_end_r;
`else
    assign cap_end_s = DEPTH_CNT;
`endif

    assign trigger_s  = trig & din_valid;
    assign addr_inc_s = wr_addr_r + ADDRESS_WIDTH'(1'b1);
    assign cnt_inc_s  = wr_count_r + (ADDRESS_WIDTH+1)'(1'b1);

    // Next-state, counter and write-enable decode.
    always_comb begin
        state_nxt_s     = state_r;
        wr_addr_nxt_s   = wr_addr_r;
        wr_count_nxt_s  = wr_count_r;
        trig_addr_nxt_s = trig_addr_r;
        we_s            = 1'b0;
`ifdef SAMPLE_CAPTURE_PRETRIG_EN
        cap_end_nxt_s   = cap_end_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (arm) begin
                    state_nxt_s    = ARMED;
                    wr_addr_nxt_s  = '0;
                    wr_count_nxt_s = '0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ARMED: begin
`ifdef SAMPLE_CAPTURE_PRETRIG_EN
                if (din_valid) begin
                    we_s          = 1'b1;
                    wr_addr_nxt_s = addr_inc_s;
                    if (trigger_s) begin
                        trig_addr_nxt_s = wr_addr_r;
                        wr_count_nxt_s  = cnt_inc_s;
                        cap_end_nxt_s   = wr_count_r + POST_CNT;
                        if (cnt_inc_s == (wr_count_r + POST_CNT)) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = CAPTURE;
                        end
                    end else if (wr_count_r >= PRE_CNT) begin
                        wr_count_nxt_s = PRE_CNT;
                    end else begin
                        wr_count_nxt_s = cnt_inc_s;
                    end
                end else begin
                    state_nxt_s = ARMED;
                end
`else
                if (trigger_s) begin
                    we_s            = 1'b1;
                    trig_addr_nxt_s = wr_addr_r;
                    wr_addr_nxt_s   = addr_inc_s;
                    wr_count_nxt_s  = cnt_inc_s;
                    if (cnt_inc_s == DEPTH_CNT) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CAPTURE;
                    end
                end else begin
                    state_nxt_s = ARMED;
                end
`endif
            end
            CAPTURE: begin
                if (din_valid) begin
                    we_s           = 1'b1;
                    wr_addr_nxt_s  = addr_inc_s;
                    wr_count_nxt_s = cnt_inc_s;
                    if (cnt_inc_s == cap_end_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CAPTURE;
                    end
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counters and status flags; flags decode the next state so they
    // line up with state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            wr_addr_r   <= '0;
            wr_count_r  <= '0;
            trig_addr_r <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SAMPLE_CAPTURE_PRETRIG_EN
            cap_end_r   <= DEPTH_CNT;
`endif
        end else begin
            state_r     <= state_nxt_s;
            wr_addr_r   <= wr_addr_nxt_s;
            wr_count_r  <= wr_count_nxt_s;
            trig_addr_r <= trig_addr_nxt_s;
            busy_r      <= (state_nxt_s == ARMED) || (state_nxt_s == CAPTURE);
            done_r      <= (state_nxt_s == DONE);
`ifdef SAMPLE_CAPTURE_PRETRIG_EN
            cap_end_r   <= cap_end_nxt_s;
`endif
        end
    end

    capture_ram #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we_s),
        .waddr(wr_addr_r),
        .wdata(din),
        .raddr(rd_addr),
        .rdata(dout)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign wr_count  = wr_count_r;
    assign trig_addr = trig_addr_r;

endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: directed, table-driven bench for sample_capture with
// ADDRESS_WIDTH=4, DATA_WIDTH=8, PRE_DEPTH=4.
module tb_sample_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arm, trig, din_valid;
    logic [7:0] din;
    logic [3:0] rd_addr;
    logic [7:0] dout;
    logic       busy, done;
    logic [4:0] wr_count;
    logic [3:0] trig_addr;

    int n_checks = 0;
    int n_fail   = 0;

    sample_capture #(
        .ADDRESS_WIDTH(4),
        .DATA_WIDTH   (8),
        .PRE_DEPTH    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .trig     (trig),
        .din_valid(din_valid),
        .din      (din),
        .rd_addr  (rd_addr),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count),
        .trig_addr(trig_addr)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       t;
        logic       v;
        logic [7:0] d;
        logic [3:0] rd;
        logic       eb;
        logic       ed;
        logic [4:0] ec;
        logic       cd;
        logic [7:0] edout;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic a, input logic t, input logic v,
                                input logic [7:0] d, input logic [3:0] rd,
                                input logic eb, input logic ed, input logic [4:0] ec,
                                input logic cd, input logic [7:0] edout);
        vec_t x;
        x.a = a; x.t = t; x.v = v; x.d = d; x.rd = rd;
        x.eb = eb; x.ed = ed; x.ec = ec; x.cd = cd; x.edout = edout;
        vecs.push_back(x);
    endfunction

    // Readback of all 16 entries while sitting in DONE.
    function automatic void add_readback(input logic [7:0] base);
        for (int k = 0; k < 16; k++) begin
            add(1'b0, 1'b0, 1'b0, 8'h00, 4'(k), 1'b0, 1'b1, 5'd16, 1'b1, 8'(base + 8'(k)));
        end
    endfunction

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            arm       = vecs[i].a;
            trig      = vecs[i].t;
            din_valid = vecs[i].v;
            din       = vecs[i].d;
            rd_addr   = vecs[i].rd;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(vecs[i].eb));
            check($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(vecs[i].ed));
            check($sformatf("%s[%0d] wr_count", tag, i), 32'(wr_count), 32'(vecs[i].ec));
            if (vecs[i].cd) begin
                check($sformatf("%s[%0d] dout", tag, i), 32'(dout), 32'(vecs[i].edout));
            end
        end
        arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
        vecs.delete();
    endtask

    initial begin
        int k;
        rst_n = 1'b0; arm = 1'b0; trig = 1'b0; din_valid = 1'b0;
        din = 8'h00; rd_addr = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wr_count", 32'(wr_count), 32'd0);
        check("reset trig_addr", 32'(trig_addr), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        rst_n = 1'b1;

        // Basic capture; trig in the arm cycle must be ignored.
        add(1'b1, 1'b1, 1'b1, 8'hEE, 4'h0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            add(1'b0, (i == 0), 1'b1, 8'(8'h10 + 8'(i)), 4'(i),
                (i != 15), (i == 15), 5'(i + 1), 1'b0, 8'h00);
        end
        add_readback(8'h10);
        run_vecs("basic");
        check("basic trig_addr", 32'(trig_addr), 32'd0);

        // Re-arm from DONE, stalled stream, arm mid-capture, read-old collisions.
        add(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        k = 0;
        for (int j = 0; j < 32; j++) begin
            if (j % 2 == 0) begin
                add((j == 10), 1'b1, 1'b1, 8'(8'hA0 + 8'(k)), 4'(k),
                    (k != 15), (k == 15), 5'(k + 1), 1'b1, 8'(8'h10 + 8'(k)));
                k++;
            end else begin
                add(1'b0, 1'b1, 1'b0, 8'h55, 4'h0, (k < 16), (k == 16), 5'(k), 1'b0, 8'h00);
            end
        end
        add_readback(8'hA0);
        run_vecs("rearm");

        // Reset after five writes of a fresh capture.
        add(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            add(1'b0, (i == 0), 1'b1, 8'(8'h10 + 8'(i)), 4'h0, 1'b1, 1'b0, 5'(i + 1), 1'b0, 8'h00);
        end
        run_vecs("partial");
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset wr_count", 32'(wr_count), 32'd0);
        check("midreset dout", 32'(dout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            add(1'b0, 1'b0, 1'b0, 8'h00, 4'(i), 1'b0, 1'b0, 5'd0, 1'b1,
                (i < 5) ? 8'(8'h10 + 8'(i)) : 8'hA5);
        end
        run_vecs("afterreset");

`ifdef SAMPLE_CAPTURE_PRETRIG_EN
        // Pre-trigger: 20 samples while armed, trigger on 0x14 at address 4.
        add(1'b1, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 5'd0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            add(1'b0, 1'b0, 1'b1, 8'(i), 4'h0, 1'b1, 1'b0, (i < 4) ? 5'(i + 1) : 5'd4, 1'b0, 8'h00);
        end
        for (int i = 0; i < 12; i++) begin
            add(1'b0, (i == 0), 1'b1, 8'(8'h14 + 8'(i)), 4'h0,
                (i != 11), (i == 11), 5'(i + 5), 1'b0, 8'h00);
        end
        add_readback(8'h10);
        run_vecs("pretrig");
        check("pretrig trig_addr", 32'(trig_addr), 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
